// File: rtl/cpu_pkg.sv
// Shared defaults and helpers for the ID-stage register file and scoreboard.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Net change of the busy population for one cycle: at most one new set, at most two clears.
    function automatic int busy_delta(input logic inc, input logic dec0, input logic dec1);
        return int'(inc) - int'(dec0) - int'(dec1);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: zero-register override, write bypass and busy qualification.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int FORWARD  = 1
) (
    input  logic [ADDR_W-1:0]                      ra_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs_i,
    input  logic [(1<<ADDR_W)-1:0]                 busy_i,
    input  logic                                   we0_i,
    input  logic [ADDR_W-1:0]                      wa0_i,
    input  logic [DATA_W-1:0]                      wd0_i,
    input  logic                                   we1_i,
    input  logic [ADDR_W-1:0]                      wa1_i,
    input  logic [DATA_W-1:0]                      wd1_i,
    output logic [DATA_W-1:0]                      rd_o,
    output logic                                   rbusy_o
);

    logic hit0, hit1, is_zero;

    assign hit0    = (FORWARD != 0) && we0_i && (wa0_i == ra_i);
    assign hit1    = (FORWARD != 0) && we1_i && (wa1_i == ra_i);
    assign is_zero = (ZERO_REG != 0) && (ra_i == ADDR_W'(REG_ZERO));

    // Later assignments take priority: zero reg, then load port, then ALU port.
    always_comb begin
        rd_o    = regs_i[ra_i];
        rbusy_o = busy_i[ra_i] && !(hit0 || hit1);
        if (hit0)    rd_o = wd0_i;
        if (hit1)    rd_o = wd1_i;
        if (is_zero) begin
            rd_o    = '0;
            rbusy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, dual-write register file with per-entry pending-write scoreboard and busy count.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int FORWARD  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_RD*ADDR_W-1:0]   ra_i,
    output logic [N_RD*DATA_W-1:0]   rd_o,
    output logic [N_RD-1:0]          rbusy_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        wa0_i,
    input  logic [DATA_W-1:0]        wd0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        wa1_i,
    input  logic [DATA_W-1:0]        wd1_i,
    input  logic                     bset_i,
    input  logic [ADDR_W-1:0]        ba_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         w0_ok, w1_ok, set_ok;
    logic                         inc, dec0, dec1;

    // Writes and sets aimed at the hardwired zero register are dropped up front.
    assign w0_ok  = we0_i  && !((ZERO_REG != 0) && (wa0_i == ADDR_W'(REG_ZERO)));
    assign w1_ok  = we1_i  && !((ZERO_REG != 0) && (wa1_i == ADDR_W'(REG_ZERO)));
    assign set_ok = bset_i && !((ZERO_REG != 0) && (ba_i  == ADDR_W'(REG_ZERO)));

    // Port 1 after port 0 so it wins an address tie; set after clears so a new producer wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (w0_ok)  mem_d[wa0_i]  = wd0_i;
        if (w1_ok)  mem_d[wa1_i]  = wd1_i;
        if (w0_ok)  busy_d[wa0_i] = 1'b0;
        if (w1_ok)  busy_d[wa1_i] = 1'b0;
        if (set_ok) busy_d[ba_i]  = 1'b1;
    end

    // Incremental count: only edges that really flip a busy bit contribute.
    always_comb begin
        inc   = set_ok && !busy_q[ba_i];
        dec0  = w0_ok && busy_q[wa0_i] && !(set_ok && (ba_i == wa0_i));
        dec1  = w1_ok && busy_q[wa1_i] && !(set_ok && (ba_i == wa1_i))
                && !(w0_ok && (wa0_i == wa1_i));
        cnt_d = CW'(int'(cnt_q) + busy_delta(inc, dec0, dec1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .FORWARD  (FORWARD)
        ) u_rp (
            .ra_i    (ra_i[k*ADDR_W +: ADDR_W]),
            .regs_i  (mem_q),
            .busy_i  (busy_q),
            .we0_i   (we0_i),
            .wa0_i   (wa0_i),
            .wd0_i   (wd0_i),
            .we1_i   (we1_i),
            .wa1_i   (wa1_i),
            .wd1_i   (wd1_i),
            .rd_o    (rd_o[k*DATA_W +: DATA_W]),
            .rbusy_o (rbusy_o[k])
        );
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default, no-forward and 3-bit-address instances share stimulus.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  ra;
    logic        we0, we1, bset;
    logic [4:0]  wa0, wa1, ba;
    logic [31:0] wd0, wd1;
    logic [63:0] rd_a, rd_b, rd_c;
    logic [1:0]  rbusy_a, rbusy_b, rbusy_c;
    logic [5:0]  cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    typedef struct { string nm; logic [63:0] v; } exp_t;
    exp_t        sb[$];
    logic [63:0] obs_q[$];

    always #5 clk = ~clk;

    reg_file_sb #(.FORWARD(1)) u_a (
        .clk(clk), .reset_n(reset_n), .ra_i(ra), .rd_o(rd_a), .rbusy_o(rbusy_a),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .bset_i(bset), .ba_i(ba), .busy_cnt_o(cnt_a));

    reg_file_sb #(.FORWARD(0)) u_b (
        .clk(clk), .reset_n(reset_n), .ra_i(ra), .rd_o(rd_b), .rbusy_o(rbusy_b),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .bset_i(bset), .ba_i(ba), .busy_cnt_o(cnt_b));

    reg_file_sb #(.ADDR_W(3)) u_c (
        .clk(clk), .reset_n(reset_n), .ra_i({ra[7:5], ra[2:0]}), .rd_o(rd_c), .rbusy_o(rbusy_c),
        .we0_i(we0), .wa0_i(wa0[2:0]), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1[2:0]), .wd1_i(wd1),
        .bset_i(bset), .ba_i(ba[2:0]), .busy_cnt_o(cnt_c));

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0; wa0 = 0; wa1 = 0; ba = 0; wd0 = 0; wd1 = 0;
    endtask

    // Pairs each queued expectation with the observation captured at the same point.
    task automatic drain();
        exp_t        e;
        logic [63:0] o;
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s got %0h want %0h", e.nm, o, e.v);
            end
        end
        if (sb.size() != obs_q.size()) begin
            checks++; errors++;
            $display("FAIL sb_align got %0d want %0d", obs_q.size(), sb.size());
            sb.delete(); obs_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); idle(); reset_n = 0;
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; idle(); ra = 0;
        repeat (2) @(negedge clk);
        ra[4:0] = 5;
        sb.push_back('{"rst_rd", 64'h0}); sb.push_back('{"rst_cnt", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(cnt_a));
        @(negedge clk); reset_n = 1;
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; bset = 1; ba = 6;
        @(negedge clk); idle();
        sb.push_back('{"wr_r5", 64'hDEADBEEF}); sb.push_back('{"cnt_pre", 64'h1});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(cnt_a));
        #2 reset_n = 0;
        sb.push_back('{"rst_async_rd", 64'h0}); sb.push_back('{"rst_async_cnt", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(cnt_a));
        we0 = 1; wa0 = 5; wd0 = 32'h1234; bset = 1; ba = 7;
        @(negedge clk); idle(); reset_n = 1;
        sb.push_back('{"rst_inflight_rd", 64'h0}); sb.push_back('{"rst_inflight_cnt", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(cnt_a));
        drain();
    endtask

    task automatic test_bypass();
        @(negedge clk); idle(); ra = 0; ra[4:0] = 3;
        we0 = 1; wa0 = 3; wd0 = 32'h11;
        sb.push_back('{"byp_fwd", 64'h11}); sb.push_back('{"byp_nofwd_old", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(rd_b[31:0]));
        @(negedge clk); idle();
        sb.push_back('{"byp_nofwd_next", 64'h11});
        #1 obs_q.push_back(64'(rd_b[31:0]));
        drain();
    endtask

    task automatic test_dual_write();
        @(negedge clk); idle(); ra = 0; ra[9:5] = 7;
        we0 = 1; wa0 = 7; wd0 = 32'hAAAA; we1 = 1; wa1 = 7; wd1 = 32'h5555;
        sb.push_back('{"dual_same_cycle", 64'h5555});
        #1 obs_q.push_back(64'(rd_a[63:32]));
        @(negedge clk); idle();
        sb.push_back('{"dual_next_a", 64'h5555}); sb.push_back('{"dual_next_b", 64'h5555});
        #1 obs_q.push_back(64'(rd_a[63:32])); obs_q.push_back(64'(rd_b[63:32]));
        drain();
    endtask

    task automatic test_zero_reg();
        @(negedge clk); idle(); ra = 0;
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; bset = 1; ba = 0;
        sb.push_back('{"zero_fwd_rd", 64'h0}); sb.push_back('{"zero_fwd_busy", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(rbusy_a[0]));
        @(negedge clk); idle();
        sb.push_back('{"zero_rd", 64'h0}); sb.push_back('{"zero_busy", 64'h0});
        sb.push_back('{"zero_cnt", 64'h0});
        #1 obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(rbusy_a[0]));
        obs_q.push_back(64'(cnt_a));
        drain();
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle(); ra = 0; ra[4:0] = 9; ra[9:5] = 9;
        sb.push_back('{"sb_idle_busy", 64'h0});
        #1 obs_q.push_back(64'(rbusy_a[0]));
        bset = 1; ba = 9;
        @(negedge clk);
        sb.push_back('{"sb_set_busy", 64'h1}); sb.push_back('{"sb_set_cnt", 64'h1});
        #1 obs_q.push_back(64'(rbusy_a[0])); obs_q.push_back(64'(cnt_a));
        @(negedge clk); idle();
        sb.push_back('{"sb_reset_cnt", 64'h1});
        #1 obs_q.push_back(64'(cnt_a));
        we1 = 1; wa1 = 9; wd1 = 32'h99; bset = 1; ba = 9;
        @(negedge clk); idle();
        sb.push_back('{"sb_setclr_busy", 64'h1}); sb.push_back('{"sb_setclr_cnt", 64'h1});
        #1 obs_q.push_back(64'(rbusy_b[1])); obs_q.push_back(64'(cnt_a));
        we1 = 1; wa1 = 9; wd1 = 32'h9A;
        sb.push_back('{"sb_wb_fwd_busy", 64'h0}); sb.push_back('{"sb_wb_nofwd_busy", 64'h1});
        #1 obs_q.push_back(64'(rbusy_a[0])); obs_q.push_back(64'(rbusy_b[0]));
        @(negedge clk); idle();
        sb.push_back('{"sb_clr_cnt", 64'h0}); sb.push_back('{"sb_clr_busy", 64'h0});
        #1 obs_q.push_back(64'(cnt_a)); obs_q.push_back(64'(rbusy_a[0]));
        bset = 1; ba = 10;
        @(negedge clk); ba = 11;
        @(negedge clk); idle(); we0 = 1; wa0 = 10; we1 = 1; wa1 = 11;
        sb.push_back('{"sb_two_cnt", 64'h2});
        #1 obs_q.push_back(64'(cnt_a));
        @(negedge clk); idle(); bset = 1; ba = 12;
        sb.push_back('{"sb_dec2_cnt", 64'h0});
        #1 obs_q.push_back(64'(cnt_a));
        @(negedge clk); idle(); we0 = 1; wa0 = 12; we1 = 1; wa1 = 12;
        @(negedge clk); idle();
        sb.push_back('{"sb_same_addr_clr_cnt", 64'h0});
        #1 obs_q.push_back(64'(cnt_a));
        drain();
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); idle(); bset = 1; ba = 5'(i);
        end
        @(negedge clk); idle(); bset = 1; ba = 0; ra = 0; ra[2:0] = 2; ra[7:5] = 4;
        sb.push_back('{"sat_cnt7", 64'h7});
        #1 obs_q.push_back(64'(cnt_c));
        @(negedge clk); idle();
        sb.push_back('{"sat_cnt7_zero_set", 64'h7}); sb.push_back('{"sat_busy_r2", 64'h1});
        #1 obs_q.push_back(64'(cnt_c)); obs_q.push_back(64'(rbusy_c[0]));
        we0 = 1; wa0 = 2; wd0 = 32'h22; we1 = 1; wa1 = 4; wd1 = 32'h44;
        @(negedge clk); idle();
        sb.push_back('{"sat_cnt5", 64'h5}); sb.push_back('{"sat_rd_r4", 64'h44});
        #1 obs_q.push_back(64'(cnt_c)); obs_q.push_back(64'(rd_c[63:32]));
        drain();
    endtask

    // Independent model of instance A under random traffic biased onto a few registers.
    task automatic test_random();
        logic [31:0] mem [32];
        logic        bsy [32];
        logic [4:0]  r [2];
        logic [31:0] er;
        logic        eb;
        int          pc;
        pulse_reset();
        for (int i = 0; i < 32; i++) begin mem[i] = 0; bsy[i] = 0; end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            bset = 1'($urandom); ba = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ba = 5'($urandom);
            r[0] = 5'($urandom_range(0, 8)); r[1] = 5'($urandom);
            ra = {r[1], r[0]};
            pc = 0;
            for (int i = 0; i < 32; i++) pc += int'(bsy[i]);
            for (int k = 0; k < 2; k++) begin
                if (r[k] == 0)                   er = 0;
                else if (we1 && wa1 == r[k])     er = wd1;
                else if (we0 && wa0 == r[k])     er = wd0;
                else                             er = mem[r[k]];
                eb = (r[k] != 0) && bsy[r[k]] && !((we0 && wa0 == r[k]) || (we1 && wa1 == r[k]));
                sb.push_back('{"rand_rd", 64'(er)});
                sb.push_back('{"rand_busy", 64'(eb)});
            end
            sb.push_back('{"rand_cnt", 64'(pc)});
            #1;
            obs_q.push_back(64'(rd_a[31:0])); obs_q.push_back(64'(rbusy_a[0]));
            obs_q.push_back(64'(rd_a[63:32])); obs_q.push_back(64'(rbusy_a[1]));
            obs_q.push_back(64'(cnt_a));
            if (we0 && wa0 != 0) begin mem[wa0] = wd0; bsy[wa0] = 0; end
            if (we1 && wa1 != 0) begin mem[wa1] = wd1; bsy[wa1] = 0; end
            if (bset && ba != 0) bsy[ba] = 1;
            drain();
        end
        @(negedge clk); idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
